// File: rtl/float_rounder_pipe.sv
// -----------------------------------------------------------------------------
// float_rounder_pipe
//
// Two-stage valid/ready pipeline that rounds an IN_WIDTH-bit unrounded
// significand to OUT_WIDTH bits. Four rounding modes are supported:
// nearest-even, toward zero, away from zero, and round-to-odd (jam).
//
// Stage 1 splits the input into the kept bits K, the guard bit G, the round
// bit R and the sticky bit S, and registers them together with the mode.
// Stage 2 registers the rounded result.
//
// Ports
//   clock       sole clock, rising edge
//   resetN      asynchronous active-low reset
//   inValid     input beat present
//   inReady     input beat accepted this cycle (no path from inValid)
//   inMant      unrounded magnitude, IN_WIDTH bits
//   inMode      00 nearest-even, 01 toward zero, 10 away from zero, 11 jam
//   outValid    result beat present
//   outReady    downstream accepts the result this cycle
//   outMant     rounded significand, modulo 2^OUT_WIDTH
//   outCarry    rounding overflowed past all-ones (true result 2^OUT_WIDTH)
//   outInexact  at least one dropped bit was nonzero
// -----------------------------------------------------------------------------
module float_rounder_pipe #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 24
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [IN_WIDTH-1:0]  inMant,
  input  logic [1:0]           inMode,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [OUT_WIDTH-1:0] outMant,
  output logic                 outCarry,
  output logic                 outInexact
);

  // Number of bits below the round bit that fold into sticky.
  localparam int LOW_W = IN_WIDTH - OUT_WIDTH - 2;

  // ---------------------------------------------------------------------------
  // Field split of the incoming beat
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] k_in;
  logic                 g_in;
  logic                 r_in;
  logic                 s_in;

  assign k_in = inMant[IN_WIDTH-1 -: OUT_WIDTH];
  assign g_in = inMant[LOW_W+1];
  assign r_in = inMant[LOW_W];

  generate
    if (LOW_W > 0) begin : g_sticky
      assign s_in = |inMant[LOW_W-1:0];
    end else begin : g_no_sticky
      // Nothing lies below the round bit.
      assign s_in = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                 s1_valid_q, s1_valid_d;
  logic [OUT_WIDTH-1:0] k_q, k_d;
  logic                 g_q, g_d;
  logic                 r_q, r_d;
  logic                 s_q, s_d;
  logic [1:0]           mode_q, mode_d;

  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_mant_q, out_mant_d;
  logic                 out_carry_q, out_carry_d;
  logic                 out_inexact_q, out_inexact_d;

  // Stage 2 can load when it is empty or its beat leaves this cycle; stage 1
  // can load under the same condition applied to itself.
  logic s2_ready;
  assign s2_ready = !out_valid_q | outReady;
  assign inReady  = !s1_valid_q | s2_ready;

  // ---------------------------------------------------------------------------
  // Rounding of the stage-1 contents
  // ---------------------------------------------------------------------------
  logic                 lost;
  logic                 inc;
  logic [OUT_WIDTH:0]   sum;
  logic [OUT_WIDTH-1:0] rnd_mant;
  logic                 rnd_carry;

  always_comb begin
    lost = g_q | r_q | s_q;
    inc  = 1'b0;
    case (mode_q)
      2'b00:   inc = g_q & (r_q | s_q | k_q[0]);  // tie rounds to even
      2'b10:   inc = lost;
      default: inc = 1'b0;                        // toward zero, jam
    endcase
    sum = {1'b0, k_q} + {{OUT_WIDTH{1'b0}}, inc};
    if (mode_q == 2'b11) begin
      // Jam: OR every discarded bit into the LSB; can never carry out.
      rnd_mant  = {k_q[OUT_WIDTH-1:1], k_q[0] | lost};
      rnd_carry = 1'b0;
    end else begin
      rnd_mant  = sum[OUT_WIDTH-1:0];
      rnd_carry = sum[OUT_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d    = s1_valid_q;
    k_d           = k_q;
    g_d           = g_q;
    r_d           = r_q;
    s_d           = s_q;
    mode_d        = mode_q;
    out_valid_d   = out_valid_q;
    out_mant_d    = out_mant_q;
    out_carry_d   = out_carry_q;
    out_inexact_d = out_inexact_q;

    if (inReady) begin
      s1_valid_d = inValid;
      // Data registers only move on a real transfer so idle inputs are ignored.
      if (inValid) begin
        k_d    = k_in;
        g_d    = g_in;
        r_d    = r_in;
        s_d    = s_in;
        mode_d = inMode;
      end
    end

    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_mant_d    = rnd_mant;
        out_carry_d   = rnd_carry;
        out_inexact_d = lost;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s1_valid_q    <= 1'b0;
      k_q           <= '0;
      g_q           <= 1'b0;
      r_q           <= 1'b0;
      s_q           <= 1'b0;
      mode_q        <= 2'b00;
      out_valid_q   <= 1'b0;
      out_mant_q    <= '0;
      out_carry_q   <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      k_q           <= k_d;
      g_q           <= g_d;
      r_q           <= r_d;
      s_q           <= s_d;
      mode_q        <= mode_d;
      out_valid_q   <= out_valid_d;
      out_mant_q    <= out_mant_d;
      out_carry_q   <= out_carry_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign outValid   = out_valid_q;
  assign outMant    = out_mant_q;
  assign outCarry   = out_carry_q;
  assign outInexact = out_inexact_q;

endmodule
